sigma_delta_adc: RTL and testbench

- Receive-side counterpart of the existing 1-bit sigma-delta DAC path.
- Takes the comparator bit from the external RC-integrator front end, synchronises it, and drives it back as the modulator feedback bit.
- Decimates the bitstream with a 3rd-order CIC into signed 16-bit samples, each marked by a single-cycle valid strobe.
- Feeds the lock-in mixer with the measured input signal, alongside the DDS sin/cos.

---
 rtl/lockin_pkg.sv | 26 ++
 rtl/cic3_decim.sv | 66 ++++++
 rtl/sigma_delta_adc.sv | 85 ++++++++
 tb/tb_sigma_delta_adc.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/lockin_pkg.sv
// Shared constants and helpers for the lock-in receive path.
//   CIC_ORDER  : number of integrator / comb stages in the decimator
//   OUT_W      : width of the decimated output sample
//   OUT_MAX/MIN: saturation limits of the output sample
//   cic_width  : internal CIC word width for a given log2 decimation ratio
//   out_shift  : right shift that maps the CIC gain onto the output width
package lockin_pkg;

  localparam int unsigned CIC_ORDER = 3;
  localparam int unsigned OUT_W     = 16;
  localparam int          OUT_MAX_I = 32767;
  localparam int          OUT_MIN_I = -32768;

  localparam logic [OUT_W-1:0] OUT_MAX = 16'h7FFF;
  localparam logic [OUT_W-1:0] OUT_MIN = 16'h8000;

  // Gain R**3 plus sign bit plus one bit of headroom for the full-scale +1 case.
  function automatic int unsigned cic_width(input int unsigned decim_log2);
    return CIC_ORDER * decim_log2 + 2;
  endfunction

  function automatic int unsigned out_shift(input int unsigned decim_log2);
    return CIC_ORDER * decim_log2 - (OUT_W - 1);
  endfunction

endpackage

// File: rtl/cic3_decim.sv
// Third-order CIC decimator for a 1-bit (+1/-1) bitstream.
//   clk_i    : system clock
//   rst_ni   : asynchronous active-low reset
//   bit_i    : input bit, 1 -> +1, 0 -> -1, consumed every cycle
//   raw_o    : W-bit comb output, meaningful only while strobe_o is high
//   strobe_o : high in the cycle the phase counter equals R-1
// DECIM_LOG2 is log2 of the decimation ratio R, legal range 5..10.
module cic3_decim
  import lockin_pkg::*;
#(
  parameter  int unsigned DECIM_LOG2 = 8,
  localparam int unsigned W          = cic_width(DECIM_LOG2)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         bit_i,
  output logic [W-1:0] raw_o,
  output logic         strobe_o
);

  logic [DECIM_LOG2-1:0] phase_q, phase_d;
  logic [W-1:0]          int1_q, int2_q, int3_q;
  logic [W-1:0]          int1_d, int2_d, int3_d;
  logic [W-1:0]          dly1_q, dly2_q, dly3_q;
  logic [W-1:0]          diff1, diff2, diff3;
  logic [W-1:0]          step;

  // Integrators chain combinationally so the comb sees integrator 3 as
  // updated in the strobe cycle itself; all arithmetic wraps modulo 2**W.
  always_comb begin
    step    = bit_i ? W'(1) : '1;
    int1_d  = int1_q + step;
    int2_d  = int2_q + int1_d;
    int3_d  = int3_q + int2_d;
    diff1   = int3_d - dly1_q;
    diff2   = diff1 - dly2_q;
    diff3   = diff2 - dly3_q;
    phase_d = phase_q + 1'b1;
  end

  assign strobe_o = (phase_q == '1);
  assign raw_o    = diff3;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= '0;
      int1_q  <= '0;
      int2_q  <= '0;
      int3_q  <= '0;
      dly1_q  <= '0;
      dly2_q  <= '0;
      dly3_q  <= '0;
    end else begin
      phase_q <= phase_d;
      int1_q  <= int1_d;
      int2_q  <= int2_d;
      int3_q  <= int3_d;
      if (strobe_o) begin
        dly1_q <= int3_d;
        dly2_q <= diff1;
        dly3_q <= diff2;
      end
    end
  end

endmodule

// File: rtl/sigma_delta_adc.sv
// Sigma-delta ADC receive path: comparator synchroniser, modulator feedback,
// 3rd-order CIC decimation, shift and saturation to a signed 16-bit sample.
//   clk          : system clock
//   rst_n        : asynchronous active-low reset
//   comp_in      : raw comparator bit, asynchronous to clk
//   fb_out       : feedback bit to the RC integrator (synchronised comp_in)
//   sample       : signed decimated sample, held between strobes
//   sample_valid : one-cycle pulse when sample updates, period R
//   clip         : sample was saturated (qualified by sample_valid)
// DECIM_LOG2 is log2 of the decimation ratio R, legal range 5..10.
module sigma_delta_adc
  import lockin_pkg::*;
#(
  parameter int unsigned DECIM_LOG2 = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        comp_in,
  output logic        fb_out,
  output logic [15:0] sample,
  output logic        sample_valid,
  output logic        clip
);

  localparam int unsigned W     = cic_width(DECIM_LOG2);
  localparam int unsigned SHIFT = out_shift(DECIM_LOG2);

  localparam logic signed [W-1:0] SAT_HI = W'(OUT_MAX_I);
  localparam logic signed [W-1:0] SAT_LO = W'(OUT_MIN_I);

  logic                 sync1_q, sync2_q;
  logic [W-1:0]         raw;
  logic                 strobe;
  logic signed [W-1:0]  shifted;
  logic [OUT_W-1:0]     sample_q, sample_d;
  logic                 valid_q;
  logic                 clip_q, clip_d;

  cic3_decim #(
    .DECIM_LOG2(DECIM_LOG2)
  ) u_cic (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .bit_i   (sync2_q),
    .raw_o   (raw),
    .strobe_o(strobe)
  );

  always_comb begin
    shifted  = $signed(raw) >>> SHIFT;
    clip_d   = 1'b0;
    sample_d = shifted[OUT_W-1:0];
    if (shifted > SAT_HI) begin
      sample_d = OUT_MAX;
      clip_d   = 1'b1;
    end else if (shifted < SAT_LO) begin
      sample_d = OUT_MIN;
      clip_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      clip_q   <= 1'b0;
    end else begin
      sync1_q <= comp_in;
      sync2_q <= sync1_q;
      valid_q <= strobe;
      if (strobe) begin
        sample_q <= sample_d;
        clip_q   <= clip_d;
      end
    end
  end

  assign fb_out       = sync2_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign clip         = clip_q;

endmodule

// File: tb/tb_sigma_delta_adc.sv
// Directed bench for sigma_delta_adc: a default R=256 instance checked
// against hand-computed steady-state values, plus an R=32 instance sharing
// the same stimulus and checked against a boxcar-cubed FIR reference.
module tb_sigma_delta_adc;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        comp_in = 1'b0;
  logic        fb_out, sample_valid, clip;
  logic [15:0] sample;
  logic        fb32, valid32, clip32;
  logic [15:0] sample32;

  always #5 clk = ~clk;

  sigma_delta_adc dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .comp_in     (comp_in),
    .fb_out      (fb_out),
    .sample      (sample),
    .sample_valid(sample_valid),
    .clip        (clip)
  );

  sigma_delta_adc #(
    .DECIM_LOG2(5)
  ) dut32 (
    .clk         (clk),
    .rst_n       (rst_n),
    .comp_in     (comp_in),
    .fb_out      (fb32),
    .sample      (sample32),
    .sample_valid(valid32),
    .clip        (clip32)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int pidx     = 0;
  logic d1 = 1'b0;
  logic d2 = 1'b0;

  localparam int RS   = 32;
  localparam int HLEN = 3 * RS - 2;
  localparam int HL   = 128;
  int   h  [HLEN];
  int   xh [HL];
  logic m1 = 1'b0;
  logic m2 = 1'b0;
  int   mcnt = 0, mt = 0, mk = 0;
  bit   exp_due = 1'b0;
  int   exp_s = 0, exp_c = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference for the R=32 instance: sync pipe, phase count, FIR over history.
  task automatic model_step();
    int acc;
    if (!rst_n) begin
      m1 = 1'b0; m2 = 1'b0; mcnt = 0; mt = 0; mk = 0; exp_due = 1'b0;
    end else begin
      xh[mt % HL] = m2 ? 1 : -1;
      exp_due = (mcnt == RS - 1);
      if (exp_due) begin
        acc = 0;
        for (int j = 0; j < HLEN && j <= mt; j++) acc += h[j] * xh[(mt - j) % HL];
        if (acc > 32767) begin exp_s = 32767; exp_c = 1; end
        else if (acc < -32768) begin exp_s = -32768; exp_c = 1; end
        else begin exp_s = acc; exp_c = 0; end
        mk++;
      end
      m2 = m1;
      m1 = comp_in;
      mcnt = (mcnt + 1) % RS;
      mt++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    if (exp_due || valid32) check_val("r32_valid", int'(valid32), int'(exp_due));
    if (exp_due && valid32 && mk >= 4) begin
      check_val("r32_sample", int'($signed(sample32)), exp_s);
      check_val("r32_clip", int'(clip32), exp_c);
    end
  endtask

  task automatic drive(input logic [3:0] pat);
    comp_in = pat[3 - (pidx % 4)];
    d2 = d1;
    d1 = comp_in;
    pidx++;
  endtask

  task automatic release_rst();
    #1 rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic run_phase(input logic [3:0] pat, input int nsamp, input int es, input int ec,
                           input string tag, input bit chk_first, input bit chk_fb);
    int got = 0;
    int last = 0;
    int budget = (nsamp + 1) * 256;
    int i = 0;
    while (got < nsamp && budget > 0) begin
      tick();
      budget--;
      if (chk_fb && i >= 2 && i < 10) check_val({tag, "_fb"}, int'(fb_out), int'(d2));
      if (sample_valid) begin
        got++;
        if (chk_first && got == 1) check_val({tag, "_first_cycle"}, cyc, 256);
        if (got > 1) check_val({tag, "_period"}, cyc - last, 256);
        last = cyc;
        if (got >= 4) begin
          check_val({tag, "_sample"}, int'($signed(sample)), es);
          check_val({tag, "_clip"}, int'(clip), ec);
        end
      end
      drive(pat);
      i++;
    end
    if (got < nsamp) check_val({tag, "_timeout"}, got, nsamp);
  endtask

  initial begin
    for (int a = 0; a < RS; a++)
      for (int b = 0; b < RS; b++)
        for (int c = 0; c < RS; c++)
          h[a + b + c]++;

    repeat (3) tick();
    check_val("rst_fb", int'(fb_out), 0);
    check_val("rst_sample", int'(sample), 0);
    check_val("rst_valid", int'(sample_valid), 0);
    check_val("rst_clip", int'(clip), 0);
    release_rst();

    run_phase(4'b1111, 5, 32767, 1, "ones", 1'b1, 1'b0);
    run_phase(4'b0000, 5, -32768, 0, "zeros", 1'b0, 1'b0);
    run_phase(4'b1010, 5, 0, 0, "alt", 1'b0, 1'b1);
    run_phase(4'b1110, 5, 16384, 0, "duty75", 1'b0, 1'b0);

    // Fresh start, then an asynchronous reset pulse at cycle 1000.
    rst_n = 1'b0;
    repeat (2) tick();
    release_rst();
    while (cyc < 1000) begin
      tick();
      drive(4'b1110);
    end
    #1 rst_n = 1'b0;
    #1;
    check_val("midrst_sample", int'(sample), 0);
    check_val("midrst_valid", int'(sample_valid), 0);
    check_val("midrst_clip", int'(clip), 0);
    check_val("midrst_fb", int'(fb_out), 0);
    repeat (2) tick();
    release_rst();
    run_phase(4'b1110, 5, 16384, 0, "rst75", 1'b1, 1'b0);

    // Random bitstream; the R=32 instance integrators wrap many times here.
    repeat (12000) begin
      tick();
      comp_in = 1'($urandom_range(0, 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
